// File: rtl/dac_cmd_sched.sv
// dac_cmd_sched: setpoint store and transfer scheduler for a 4-channel serial DAC.
// Define DAC_REFRESH_EN to add a periodic forced-refresh transfer.
module dac_cmd_sched #(
    parameter int HOLDOFF        = 16,
    parameter int REFRESH_PERIOD = 65536
) (
    input  logic        clkin,
    input  logic        rstn,
    input  logic        host_wen,
    input  logic [1:0]  host_wchan,
    input  logic [15:0] host_wdata,
    output logic        dac_trig,
    input  logic        dac_busy,
    input  logic [3:0]  dac_addr,
    input  logic        dac_flush,
    output logic [31:0] dac_word,
    output logic [3:0]  dirty,
    output logic [15:0] xfer_count
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_BUSY,
        XFER,
        HOLD
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);
    localparam logic [7:0] WAIT_LAST = 8'd3;

    state_t      state;
    logic [7:0]  cnt;
    logic [15:0] setpt [4];
    logic [3:0]  dirty_next;
    logic [1:0]  rd_chan;
    logic [3:0]  cmd;
    logic        start;
    logic        trig_enter;
    logic        refresh_due;
    logic        refresh_xfer;
    logic        unused_addr_bits;

    // Addresses above 3 (the engine's end-of-transfer 4) alias onto channels.
    assign rd_chan          = dac_addr[1:0];
    assign unused_addr_bits = ^dac_addr[3:2];

    assign start      = (|dirty || refresh_due) && !dac_busy;
    assign trig_enter = (state == IDLE) && start;

    assign cmd      = (dirty[rd_chan] || refresh_xfer) ? 4'h3 : 4'h7;
    assign dac_word = {8'h00, cmd, 2'b00, rd_chan, setpt[rd_chan]};

`ifdef DAC_REFRESH_EN
    localparam int TW = $clog2(REFRESH_PERIOD);
    localparam logic [TW-1:0] T_LAST = TW'(REFRESH_PERIOD - 1);

    logic [TW-1:0] timer;

    // Free-running refresh timer, restarted whenever a transfer is launched.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            timer       <= '0;
            refresh_due <= 1'b0;
        end else if (trig_enter) begin
            timer       <= '0;
            refresh_due <= 1'b0;
        end else if (!refresh_due) begin
            if (timer == T_LAST) begin
                refresh_due <= 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    // Marks a refresh-launched transfer so every word goes out as an update.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            refresh_xfer <= 1'b0;
        end else if (state == IDLE) begin
            refresh_xfer <= trig_enter && refresh_due;
        end
    end
`else
    localparam int unused_refresh_period = REFRESH_PERIOD;

    assign refresh_due  = 1'b0;
    assign refresh_xfer = 1'b0;
`endif

    // Setpoint registers, midscale out of reset.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                setpt[i] <= 16'h8000;
            end
        end else if (host_wen) begin
            setpt[host_wchan] <= host_wdata;
        end
    end

    // Flush clears the addressed channel; a same-edge write re-sets it.
    always_comb begin
        dirty_next = dirty;
        if (dac_flush) begin
            dirty_next[rd_chan] = 1'b0;
        end
        if (host_wen) begin
            dirty_next[host_wchan] = 1'b1;
        end
    end

    // Pending-update flags.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            dirty <= 4'b0000;
        end else begin
            dirty <= dirty_next;
        end
    end

    // Transfer sequencer with registered trigger and completion counter.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            dac_trig   <= 1'b0;
            cnt        <= 8'd0;
            xfer_count <= 16'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= TRIG;
                        dac_trig <= 1'b1;
                    end
                end
                TRIG: begin
                    state    <= WAIT_BUSY;
                    dac_trig <= 1'b0;
                    cnt      <= 8'd0;
                end
                WAIT_BUSY: begin
                    if (dac_busy) begin
                        state <= XFER;
                    end else if (cnt == WAIT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                XFER: begin
                    if (!dac_busy) begin
                        state      <= HOLD;
                        cnt        <= 8'd0;
                        xfer_count <= xfer_count + 16'd1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    dac_trig <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_cmd_sched.sv
// tb_dac_cmd_sched: directed vector table plus hand-written transfer sequences.
// Exercises refresh behaviour when DAC_REFRESH_EN is defined.
module tb_dac_cmd_sched;

    localparam int HO = 16;
    localparam int RP = 1024;

    logic        clkin;
    logic        rstn;
    logic        host_wen;
    logic [1:0]  host_wchan;
    logic [15:0] host_wdata;
    logic        dac_trig;
    logic        dac_busy;
    logic [3:0]  dac_addr;
    logic        dac_flush;
    logic [31:0] dac_word;
    logic [3:0]  dirty;
    logic [15:0] xfer_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    dac_cmd_sched #(
        .HOLDOFF(HO),
        .REFRESH_PERIOD(RP)
    ) dut (
        .clkin(clkin),
        .rstn(rstn),
        .host_wen(host_wen),
        .host_wchan(host_wchan),
        .host_wdata(host_wdata),
        .dac_trig(dac_trig),
        .dac_busy(dac_busy),
        .dac_addr(dac_addr),
        .dac_flush(dac_flush),
        .dac_word(dac_word),
        .dirty(dirty),
        .xfer_count(xfer_count)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    typedef struct {
        logic        wen;
        logic [1:0]  wchan;
        logic [15:0] wdata;
        logic [3:0]  addr;
        logic        flush;
        logic [31:0] exp_word;
        logic [3:0]  exp_dirty;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clkin);
        @(negedge clkin);
        cyc++;
    endtask

    // n = steps until dac_trig seen high, -1 if not within max steps
    task automatic wait_trig(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (dac_trig) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic write(input logic [1:0] ch, input logic [15:0] d);
        host_wen   = 1'b1;
        host_wchan = ch;
        host_wdata = d;
        step();
        host_wen   = 1'b0;
    endtask

    task automatic serve_start();
        dac_busy = 1'b1;
        step();
        step();
    endtask

    task automatic serve_flush(input logic [3:0] mask);
        for (int ch = 0; ch < 4; ch++) begin
            if (mask[ch]) begin
                dac_addr  = 4'(ch);
                dac_flush = 1'b1;
                step();
                dac_flush = 1'b0;
            end
        end
    endtask

    task automatic serve_end();
        dac_busy = 1'b0;
        dac_addr = 4'd4;
        step();
    endtask

    initial begin
        int n;
        int c0;
        logic [31:0] w;

        vecs[0]  = '{1'b0, 2'd0, 16'h0000, 4'd0, 1'b0, 32'h0070_8000, 4'b0000};
        vecs[1]  = '{1'b1, 2'd2, 16'h1234, 4'd2, 1'b0, 32'h0032_1234, 4'b0100};
        vecs[2]  = '{1'b0, 2'd0, 16'h0000, 4'd6, 1'b0, 32'h0032_1234, 4'b0100};
        vecs[3]  = '{1'b0, 2'd0, 16'h0000, 4'd4, 1'b0, 32'h0070_8000, 4'b0100};
        vecs[4]  = '{1'b0, 2'd0, 16'h0000, 4'd2, 1'b1, 32'h0072_1234, 4'b0000};
        vecs[5]  = '{1'b1, 2'd1, 16'hABCD, 4'd1, 1'b1, 32'h0031_ABCD, 4'b0010};
        vecs[6]  = '{1'b0, 2'd0, 16'h0000, 4'd5, 1'b1, 32'h0071_ABCD, 4'b0000};
        vecs[7]  = '{1'b1, 2'd3, 16'hFFFF, 4'd0, 1'b1, 32'h0070_8000, 4'b1000};
        vecs[8]  = '{1'b1, 2'd0, 16'h0000, 4'd3, 1'b0, 32'h0033_FFFF, 4'b1001};
        vecs[9]  = '{1'b1, 2'd0, 16'h5555, 4'd3, 1'b1, 32'h0073_FFFF, 4'b0001};
        vecs[10] = '{1'b0, 2'd0, 16'h0000, 4'd0, 1'b0, 32'h0030_5555, 4'b0001};
        vecs[11] = '{1'b0, 2'd0, 16'h0000, 4'd8, 1'b1, 32'h0070_5555, 4'b0000};

        rstn       = 1'b0;
        host_wen   = 1'b0;
        host_wchan = 2'd0;
        host_wdata = 16'h0000;
        dac_busy   = 1'b1;
        dac_addr   = 4'd0;
        dac_flush  = 1'b0;

        // reset state
        @(negedge clkin);
        @(negedge clkin);
        chk("rst_trig", 32'(dac_trig), 32'd0);
        chk("rst_dirty", 32'(dirty), 32'd0);
        chk("rst_count", 32'(xfer_count), 32'd0);
        chk("rst_word0", dac_word, 32'h0070_8000);
        dac_addr = 4'd3;
        #1;
        chk("rst_word3", dac_word, 32'h0073_8000);
        rstn = 1'b1;
        step();

        // table: busy held high so the FSM stays in IDLE
        for (int i = 0; i < 12; i++) begin
            host_wen   = vecs[i].wen;
            host_wchan = vecs[i].wchan;
            host_wdata = vecs[i].wdata;
            dac_addr   = vecs[i].addr;
            dac_flush  = vecs[i].flush;
            step();
            chk($sformatf("vec%0d_word", i), dac_word, vecs[i].exp_word);
            chk($sformatf("vec%0d_dirty", i), 32'(dirty), 32'(vecs[i].exp_dirty));
            chk($sformatf("vec%0d_trig", i), 32'(dac_trig), 32'd0);
        end
        host_wen  = 1'b0;
        dac_flush = 1'b0;
        dac_addr  = 4'd4;
        dac_busy  = 1'b0;
        step();

        // A: write-to-trig latency and one clean transfer
        host_wen   = 1'b1;
        host_wchan = 2'd2;
        host_wdata = 16'h1234;
        step();
        host_wen = 1'b0;
        chk("A_lat1", 32'(dac_trig), 32'd0);
        step();
        chk("A_lat2", 32'(dac_trig), 32'd1);
        dac_busy = 1'b1;
        step();
        chk("A_pulse", 32'(dac_trig), 32'd0);
        step();
        dac_addr = 4'd2;
        #1;
        chk("A_word", dac_word, 32'h0032_1234);
        serve_flush(4'b0100);
        serve_end();
        chk("A_dirty", 32'(dirty), 32'd0);
        chk("A_count", 32'(xfer_count), 32'd1);
        wait_trig(HO + 4, n);
        chk("A_noretrig", 32'(n), 32'hFFFF_FFFF);

        // B: engine never goes busy
        write(2'd3, 16'h0777);
        wait_trig(4, n);
        chk("B_trig", 32'(n), 32'd1);
        wait_trig(12, n);
        chk("B_retrig", 32'(n), 32'd6);
        chk("B_count", 32'(xfer_count), 32'd1);
        chk("B_dirty", 32'(dirty), 32'b1000);
        serve_start();
        serve_flush(4'b1000);
        serve_end();
        chk("B_count2", 32'(xfer_count), 32'd2);
        chk("B_dirty2", 32'(dirty), 32'd0);
        wait_trig(HO + 4, n);
        chk("B_idle", 32'(n), 32'hFFFF_FFFF);

        // C: write on the same edge as its channel's flush
        write(2'd1, 16'h1111);
        wait_trig(4, n);
        chk("C_trig", 32'(n), 32'd1);
        serve_start();
        dac_addr   = 4'd1;
        dac_flush  = 1'b1;
        host_wen   = 1'b1;
        host_wchan = 2'd1;
        host_wdata = 16'h2222;
        step();
        dac_flush = 1'b0;
        host_wen  = 1'b0;
        chk("C_dirty", 32'(dirty), 32'b0010);
        chk("C_word", dac_word, 32'h0031_2222);
        serve_end();
        chk("C_count", 32'(xfer_count), 32'd3);
        wait_trig(HO + 5, n);
        chk("C_gap", 32'(n), 32'(HO + 1));
        serve_start();
        serve_flush(4'b0010);
        serve_end();
        chk("C_dirty2", 32'(dirty), 32'd0);
        chk("C_count2", 32'(xfer_count), 32'd4);
        wait_trig(HO + 4, n);

        // D: all four channels written during XFER
        write(2'd0, 16'h0100);
        wait_trig(4, n);
        chk("D_trig", 32'(n), 32'd1);
        serve_start();
        serve_flush(4'b0001);
        for (int ch = 0; ch < 4; ch++) begin
            write(2'(ch), 16'hA000 + 16'(ch));
        end
        chk("D_dirty", 32'(dirty), 32'b1111);
        serve_end();
        chk("D_count", 32'(xfer_count), 32'd5);
        wait_trig(HO + 5, n);
        chk("D_gap", 32'(n), 32'(HO + 1));
        serve_start();
        for (int ch = 0; ch < 4; ch++) begin
            dac_addr = 4'(ch);
            #1;
            w = 32'h0030_0000 | (32'(ch) << 16) | 32'(16'hA000 + 16'(ch));
            chk($sformatf("D_word%0d", ch), dac_word, w);
        end
        serve_flush(4'b1111);
        serve_end();
        chk("D_dirty2", 32'(dirty), 32'd0);
        chk("D_count2", 32'(xfer_count), 32'd6);
        wait_trig(HO + 20, n);
        chk("D_single", 32'(n), 32'hFFFF_FFFF);

        // E: reset mid-transfer with the engine still busy
        write(2'd2, 16'h4321);
        wait_trig(4, n);
        chk("E_trig", 32'(n), 32'd1);
        serve_start();
        write(2'd1, 16'h0042);
        rstn     = 1'b0;
        dac_addr = 4'd2;
        #1;
        chk("E_trig0", 32'(dac_trig), 32'd0);
        chk("E_dirty", 32'(dirty), 32'd0);
        chk("E_count", 32'(xfer_count), 32'd0);
        chk("E_word2", dac_word, 32'h0072_8000);
        dac_addr = 4'd1;
        #1;
        chk("E_word1", dac_word, 32'h0071_8000);
        step();
        step();
        rstn = 1'b1;
        wait_trig(20, n);
        chk("E_busy_quiet", 32'(n), 32'hFFFF_FFFF);
        dac_busy = 1'b0;
        dac_addr = 4'd4;
        wait_trig(20, n);
        chk("E_idle_quiet", 32'(n), 32'hFFFF_FFFF);

`ifdef DAC_REFRESH_EN
        // F: periodic refresh with no writes
        wait_trig(RP + 100, n);
        chk("F_first", 32'(n != -1), 32'd1);
        c0 = cyc;
        serve_start();
        dac_addr = 4'd1;
        #1;
        chk("F_word1", dac_word, 32'h0031_8000);
        serve_end();
        wait_trig(RP + 100, n);
        chk("F_period", 32'(cyc - c0), 32'(RP + 1));
`else
        // F: no transfers without dirty bits
        c0 = cyc;
        wait_trig(RP + 200, n);
        chk("F_none", 32'(n), 32'hFFFF_FFFF);
        chk("F_span", 32'(cyc - c0), 32'(RP + 200));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
